// File: rtl/sobel_stoch_sched_if.sv
// sobel_stoch_sched_if: frame control, source-read, core and edge-write signals of the
// Sobel window scheduler. master = scheduler side, slave = memories/core side.
interface sobel_stoch_sched_if #(
  parameter int AW = 12
);
  logic          go;
  logic          busy;
  logic          frame_done;
  logic          src_rd;
  logic [AW-1:0] src_addr;
  logic [7:0]    src_data;
  logic [63:0]   win_bin;
  logic          core_start;
  logic          core_done;
  logic [7:0]    core_z;
  logic          edge_we;
  logic [AW-1:0] edge_addr;
  logic [7:0]    edge_data;

  // Handshakes: go is sampled only while idle. src_rd is a strobe whose data returns exactly
  // one cycle later. core_start pulses once, then the scheduler waits for core_done (ignored at
  // any other time). edge_we is a single-cycle write strobe to an always-ready edge memory.
  modport master (
    input  go, src_data, core_done, core_z,
    output busy, frame_done, src_rd, src_addr, win_bin, core_start,
           edge_we, edge_addr, edge_data
  );
  modport slave (
    output go, src_data, core_done, core_z,
    input  busy, frame_done, src_rd, src_addr, win_bin, core_start,
           edge_we, edge_addr, edge_data
  );
endinterface

// File: rtl/sobel_stoch_sched.sv
// sobel_stoch_sched: walks 3x3 windows over a ROWS x COLS image, feeds each to a stochastic
// Sobel core and writes the results. Define SOBEL_SCHED_REUSE_EN to reuse the overlapping columns.
module sobel_stoch_sched #(
  parameter int ROWS = 50,
  parameter int COLS = 50,
  parameter int AW   = 12
) (
  input  logic                clk,
  input  logic                reset,
  sobel_stoch_sched_if.master bus,
  output logic [2:0]          state_dbg
);
`ifdef SOBEL_SCHED_REUSE_EN
  localparam bit REUSE_EN = 1'b1;
`else
  localparam bit REUSE_EN = 1'b0;
`endif
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 3);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 3);

  typedef enum logic [2:0] {IDLE, FETCH, FLUSH, LAUNCH, WAIT_DONE, WRITE, FIN} state_t;
  state_t state_q, state_d;

  // r0/c0 are the window's top-left pixel, i.e. (i-1, j-1)
  logic [RW-1:0] r0;
  logic [CW-1:0] c0;
  logic [3:0]    k, k_last, pos, rd_pos;
  logic [1:0]    r_off, c_off;
  logic          rd_pend, last_read, last_win;
  logic [7:0]    win [9];
  logic [7:0]    z_q;
  logic [AW-1:0] ecnt;

  // Read slot k -> window position (row-major 0..8, centre is 4)
  always_comb begin
    k_last = 4'd7;
    pos    = (k < 4'd4) ? k : k + 4'd1;
    if (REUSE_EN) begin
      if (c0 == '0) begin
        k_last = 4'd8;
        pos    = k;
      end else begin
        k_last = 4'd2;
        pos    = {k[2:0], 1'b0} + k + 4'd2;
      end
    end
    case (pos)
      4'd0:    begin r_off = 2'd0; c_off = 2'd0; end
      4'd1:    begin r_off = 2'd0; c_off = 2'd1; end
      4'd2:    begin r_off = 2'd0; c_off = 2'd2; end
      4'd3:    begin r_off = 2'd1; c_off = 2'd0; end
      4'd4:    begin r_off = 2'd1; c_off = 2'd1; end
      4'd5:    begin r_off = 2'd1; c_off = 2'd2; end
      4'd6:    begin r_off = 2'd2; c_off = 2'd0; end
      4'd7:    begin r_off = 2'd2; c_off = 2'd1; end
      default: begin r_off = 2'd2; c_off = 2'd2; end
    endcase
  end

  assign last_read = (k == k_last);
  assign last_win  = (r0 == R_LAST) && (c0 == C_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.go) state_d = FETCH;
      FETCH:     if (last_read) state_d = FLUSH;
      FLUSH:     state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_DONE;
      WAIT_DONE: if (bus.core_done) state_d = WRITE;
      WRITE:     state_d = last_win ? FIN : FETCH;
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign bus.busy       = (state_q != IDLE) && (state_q != FIN);
  assign bus.frame_done = (state_q == FIN);
  assign bus.src_rd     = (state_q == FETCH);
  assign bus.core_start = (state_q == LAUNCH);
  assign bus.edge_we    = (state_q == WRITE);
  assign bus.edge_addr  = ecnt;
  assign bus.edge_data  = z_q;
  assign bus.src_addr   = (state_q == FETCH)
                        ? (AW'(r0) + AW'(r_off)) * AW'(COLS) + AW'(c0) + AW'(c_off)
                        : '0;
  assign bus.win_bin    = {win[8], win[7], win[6], win[5], win[3], win[2], win[1], win[0]};
  assign state_dbg      = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r0      <= '0;
      c0      <= '0;
      k       <= '0;
      rd_pend <= 1'b0;
      rd_pos  <= '0;
      z_q     <= '0;
      ecnt    <= '0;
      for (int n = 0; n < 9; n++) win[n] <= '0;
    end else begin
      rd_pend <= (state_q == FETCH);
      rd_pos  <= pos;
      if (rd_pend) win[rd_pos] <= bus.src_data;
      case (state_q)
        FETCH:     k <= last_read ? 4'd0 : k + 4'd1;
        WAIT_DONE: if (bus.core_done) z_q <= bus.core_z;
        WRITE: begin
          ecnt <= ecnt + AW'(1);
          if (!last_win) begin
            if (c0 == C_LAST) begin
              c0 <= '0;
              r0 <= r0 + RW'(1);
            end else begin
              c0 <= c0 + CW'(1);
            end
            // Slide left; a row start reloads all nine entries, so the shift is harmless there
            if (REUSE_EN) begin
              win[0] <= win[1];
              win[1] <= win[2];
              win[3] <= win[4];
              win[4] <= win[5];
              win[6] <= win[7];
              win[7] <= win[8];
            end
          end
        end
        FIN: begin
          r0   <= '0;
          c0   <= '0;
          ecnt <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sobel_stoch_sched.sv
// tb_sobel_stoch_sched: random-image frames on a 4x5 source, scored against a pixel-level
// model of the window walk, plus go/core_done misuse, FIN-coincident go and mid-frame reset.
module tb_sobel_stoch_sched;
  localparam int ROWS = 4;
  localparam int COLS = 5;
  localparam int AW   = 12;
  localparam int NPIX = ROWS * COLS;
  localparam int NWIN = (ROWS - 2) * (COLS - 2);
`ifdef SOBEL_SCHED_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] state_dbg;

  sobel_stoch_sched_if #(.AW(AW)) bus ();

  sobel_stoch_sched #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- source memory and core stub ----------------
  logic [7:0] mem [NPIX];
  int         core_mode = 0;
  int         core_lat  = 1;
  logic [7:0] lat_cnt;
  logic       inj_done  = 1'b0;

  function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
    int ai;
    ai = int'(a);
    return (ai < NPIX) ? mem[ai] : 8'hee;
  endfunction

  // mode 0 returns p3; mode 1 is an order-sensitive mix of all eight neighbours
  function automatic logic [7:0] core_f(input int mode, input logic [63:0] w);
    logic [7:0] acc;
    if (mode == 0) return w[23:16];
    acc = 8'h5a;
    for (int n = 0; n < 8; n++) acc = ((acc ^ w[n*8 +: 8]) * 8'd3) + 8'(n);
    return acc;
  endfunction

  always @(posedge clk) if (bus.src_rd) bus.src_data <= mem_rd(bus.src_addr);

  always @(posedge clk or negedge reset)
    if (!reset)              lat_cnt <= 8'd0;
    else if (bus.core_start) lat_cnt <= 8'(core_lat);
    else if (lat_cnt != 0)   lat_cnt <= lat_cnt - 8'd1;

  assign bus.core_done = (lat_cnt == 8'd1) | inj_done;
  assign bus.core_z    = core_f(core_mode, bus.win_bin);

  // ---------------- monitor ----------------
  logic [AW+7:0] act_q[$];
  int            wr_cyc_q[$];
  int            rd_cnt, start_cnt, done_cyc;

  always @(negedge clk) begin
    if (bus.edge_we) begin
      act_q.push_back({bus.edge_addr, bus.edge_data});
      wr_cyc_q.push_back(cyc);
    end
    if (bus.src_rd)     rd_cnt++;
    if (bus.core_start) start_cnt++;
    if (bus.frame_done) done_cyc = cyc;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [AW+7:0] exp_q[$];
  int            exp_n_q[$];

  function automatic logic [63:0] win_of(input int i, input int j);
    return {mem[(i+1)*COLS+j+1], mem[(i+1)*COLS+j], mem[(i+1)*COLS+j-1],
            mem[i*COLS+j+1],                        mem[i*COLS+j-1],
            mem[(i-1)*COLS+j+1], mem[(i-1)*COLS+j], mem[(i-1)*COLS+j-1]};
  endfunction

  task automatic build_expect();
    exp_q.delete();
    exp_n_q.delete();
    for (int i = 1; i <= ROWS - 2; i++)
      for (int j = 1; j <= COLS - 2; j++) begin
        exp_q.push_back({AW'((i - 1) * (COLS - 2) + (j - 1)), core_f(core_mode, win_of(i, j))});
        exp_n_q.push_back(REUSE ? ((j == 1) ? 9 : 3) : 8);
      end
  endtask

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic randomize_mem();
    for (int n = 0; n < NPIX; n++) mem[n] = 8'($urandom_range(0, 255));
  endtask

  task automatic clear_mon();
    act_q.delete();
    wr_cyc_q.delete();
    rd_cnt    = 0;
    start_cnt = 0;
    done_cyc  = -1;
  endtask

  task automatic pulse_go();
    @(posedge clk);
    #1 bus.go = 1'b1;
    @(posedge clk);
    #1 bus.go = 1'b0;
  endtask

  task automatic wait_frame_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (bus.frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_frame_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},       64'(bus.busy),       64'd0);
    check({tag, "_frame_done"}, 64'(bus.frame_done), 64'd0);
    check({tag, "_src_rd"},     64'(bus.src_rd),     64'd0);
    check({tag, "_core_start"}, 64'(bus.core_start), 64'd0);
    check({tag, "_edge_we"},    64'(bus.edge_we),    64'd0);
    check({tag, "_src_addr"},   64'(bus.src_addr),   64'd0);
    check({tag, "_edge_addr"},  64'(bus.edge_addr),  64'd0);
    check({tag, "_edge_data"},  64'(bus.edge_data),  64'd0);
    check({tag, "_win_bin"},    bus.win_bin,         64'd0);
  endtask

  task automatic verify_frame(input string tag, input int lat);
    int total_rd;
    total_rd = 0;
    foreach (exp_n_q[w]) total_rd += exp_n_q[w];
    check({tag, "_wr_count"}, 64'(act_q.size()), 64'(NWIN));
    for (int w = 0; w < NWIN && w < act_q.size(); w++)
      check($sformatf("%s_wr%0d", tag, w), 64'(act_q[w]), 64'(exp_q[w]));
    for (int w = 1; w < NWIN && w < wr_cyc_q.size(); w++)
      check($sformatf("%s_period%0d", tag, w), 64'(wr_cyc_q[w] - wr_cyc_q[w-1]),
            64'(exp_n_q[w] + 3 + lat));
    check({tag, "_rd_count"}, 64'(rd_cnt), 64'(total_rd));
    if (wr_cyc_q.size() > 0)
      check({tag, "_done_after_last_wr"}, 64'(done_cyc), 64'(wr_cyc_q[wr_cyc_q.size()-1] + 1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit found;
    bus.go = 1'b0;
    clear_mon();

    // reset state
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // frame A: core returns p3, single-cycle core latency
    randomize_mem();
    core_mode = 0;
    core_lat  = 1;
    build_expect();
    clear_mon();
    pulse_go();
    check("A_busy_after_go", 64'(bus.busy), 64'd1);
    wait_frame_done("A");
    check("A_busy_in_fin", 64'(bus.busy), 64'd0);
    repeat (2) @(negedge clk);
    verify_frame("A", 1);

    // frame B: 20-cycle core, go pulsed mid-window, stray core_done during FETCH, go during FIN
    randomize_mem();
    core_mode = 1;
    core_lat  = 20;
    build_expect();
    clear_mon();
    pulse_go();
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      @(negedge clk);
      found = bus.src_rd;
    end
    check("B_fetch_seen", 64'(found), 64'd1);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      @(negedge clk);
      found = (lat_cnt > 8'd1);
    end
    check("B_wait_seen", 64'(found), 64'd1);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    wait_frame_done("B");
    bus.go = 1'b1;
    @(posedge clk);
    #1 bus.go = 1'b0;
    repeat (10) @(negedge clk);
    check("B_fin_go_ignored_busy", 64'(bus.busy), 64'd0);
    verify_frame("B", 20);

    // frame C: reset while waiting on the core for window 2, then a full rerun
    randomize_mem();
    core_mode = 1;
    core_lat  = $urandom_range(2, 6);
    build_expect();
    clear_mon();
    pulse_go();
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      @(negedge clk);
      found = (start_cnt == 2) && (lat_cnt > 8'd1);
    end
    check("C_wait2_seen", 64'(found), 64'd1);
    #1 reset = 1'b0;
    #1 check_outputs_zero("C_async_reset");
    check("C_writes_before_reset", 64'(act_q.size()), 64'd1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(negedge clk);
    check("C_no_write_after_reset", 64'(act_q.size()), 64'd1);
    check("C_idle_after_reset", 64'(bus.busy), 64'd0);
    clear_mon();
    pulse_go();
    wait_frame_done("C_rerun");
    repeat (2) @(negedge clk);
    verify_frame("C_rerun", core_lat);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sobel_stoch_sched.md
SOBEL_STOCH_SCHED -- requirements
Module: sobel_stoch_sched

Interface
REQ-001 SHALL have parameter ROWS, default 50, source image rows (≥3).
REQ-002 SHALL have parameter COLS, default 50, source image columns (≥3).
REQ-003 SHALL have parameter AW, default 12, source/edge address width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 go  in  1  frame request, sampled in IDLE only.
REQ-007 busy  out  1  high from the cycle after go is accepted until frame_done.
REQ-008 frame_done  out  1  one-cycle pulse after the last edge write.
REQ-009 src_rd  out  1  source memory read strobe.
REQ-010 src_addr  out  AW  linear source address, row*COLS+col.
REQ-011 src_data  in  8  read data, valid exactly one cycle after src_rd.
REQ-012 win_bin  out  64  {p9,p8,p7,p6,p4,p3,p2,p1}, p1 in [7:0]; centre p5 excluded.
REQ-013 core_start  out  1  one-cycle pulse launching the stochastic Sobel core.
REQ-014 core_done  in  1  core completion, sampled only in WAIT_DONE.
REQ-015 core_z  in  8  core result, valid while core_done is high.
REQ-016 edge_we  out  1  edge memory write strobe.
REQ-017 edge_addr  out  AW  compact address (i-1)*(COLS-2)+(j-1).
REQ-018 edge_data  out  8  captured core_z.

Function
REQ-019 FSM states: IDLE, FETCH, FLUSH, LAUNCH, WAIT_DONE, WRITE, FIN.
- IDLE -> FETCH on go.
- FETCH -> FLUSH after the last read.
- FLUSH -> LAUNCH; FLUSH captures the last read datum.
- LAUNCH -> WAIT_DONE.
- WAIT_DONE -> WRITE when core_done=1.
- WRITE -> FETCH for the next window, or -> FIN after the last window.
- FIN -> IDLE.
REQ-020 Windows SHALL be visited with centre (i,j), i=1..ROWS-2 outer, j=1..COLS-2 inner.
REQ-021 FETCH SHALL issue one read per cycle, src_rd high each FETCH cycle, order row-major within the window; read count is set by REQ-034/035.
REQ-022 Each datum SHALL be written into a 9-entry internal window register one cycle after its read.
REQ-023 win_bin SHALL be stable from LAUNCH until WRITE exits.
REQ-024 core_start SHALL be high only in LAUNCH.
REQ-025 core_z SHALL be captured in the WAIT_DONE cycle where core_done=1.
REQ-026 WRITE SHALL assert edge_we for exactly one cycle with edge_addr/edge_data per REQ-017/018.
REQ-027 Per-window cycle count SHALL be N+1+1+L+1, where N = reads issued and L = WAIT_DONE cycles including the core_done cycle.
REQ-028 Boundary conditions:
- go while busy: ignored.
- core_done outside WAIT_DONE: ignored.
- go coincident with FIN: ignored; a new frame needs go in IDLE.
REQ-029 Window and edge counters SHALL wrap to zero only via FIN; exactly (ROWS-2)*(COLS-2) edge writes per frame.
REQ-030 frame_done SHALL be high only in FIN; busy low in IDLE and FIN.

Reset
REQ-031 reset low SHALL asynchronously force IDLE and clear all counters and window registers.
REQ-032 Reset values: busy, frame_done, src_rd, core_start, edge_we = 0; src_addr, edge_addr, edge_data, win_bin = 0.
REQ-033 Reset mid-frame SHALL abandon the frame with no further writes; operation resumes only on a new go after reset release.

Configuration
REQ-034 With SOBEL_SCHED_REUSE_EN defined:
- First window of each row (j=1) reads all 9 pixels.
- Subsequent windows shift the window one column left and read only the 3 new right-column pixels (rows i-1,i,i+1, col j+1): N=3.
REQ-035 Without SOBEL_SCHED_REUSE_EN:
- Every window reads 8 pixels, skipping the centre: N=8.
- Centre entry stays 0.
REQ-036 Results and write order SHALL be identical in both configurations.

Verification
REQ-037 ROWS=COLS=3, src = 0x01..0x09, core model done 3 cycles after start returning p1 -> one write, edge_addr=0, edge_data=0x01, then frame_done.
REQ-038 ROWS=4, COLS=5, core_z = p3 -> 6 writes at addresses 0..5 in order; values equal src[(i-1)*5+j+1]; identical with and without REUSE_EN.
REQ-039 Same frame, count src_rd pulses -> 48 without REUSE_EN; 2*9+4*3=30 with it.
REQ-040 go pulsed during WAIT_DONE, and core_done pulsed during FETCH -> no extra window, no extra write, write count unchanged.
REQ-041 reset asserted in WAIT_DONE of window 2 -> all outputs 0 asynchronously; no edge_we until a new go; the rerun produces the full, correct write sequence.
REQ-042 Core latency L=1 vs L=20 -> per-window cycles 12 vs 31 without REUSE_EN.
